// File: rtl/button_conditioner.sv
// button_conditioner: N-channel push-button front end.
// Each channel: 2-FF synchroniser, optional inversion, debounce, press/release
// pulses, toggle flag, long-press detect and optional auto-repeat press pulses.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_UP    | debounced level low (released)
//  ST_DOWN  | debounced level high, hold timer counting toward long-press
//  ST_LONG  | held >= HOLD_CYC cycles; timer paces auto-repeat if enabled
module button_conditioner #(
  parameter int              N_CH         = 4,
  parameter int              DEBOUNCE_CYC = 1000000,
  parameter int              HOLD_CYC     = 50000000,
  parameter int              REPEAT_CYC   = 10000000,
  parameter logic [N_CH-1:0] REPEAT_MASK  = '0,
  parameter logic [N_CH-1:0] INVERT_MASK  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_raw,
  input  logic [N_CH-1:0] toggle_clr,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_toggle,
  output logic [N_CH-1:0] o_long
);

  localparam int DW_RAW = $clog2(DEBOUNCE_CYC + 1);
  localparam int DW     = (DW_RAW < 1) ? 1 : DW_RAW;
  localparam int HW_RAW = $clog2(HOLD_CYC + 1);
  localparam int RW_RAW = $clog2(REPEAT_CYC + 1);
  localparam int TW_RAW = (HW_RAW > RW_RAW) ? HW_RAW : RW_RAW;
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] REP_LOAD  = TW'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {
    ST_UP   = 2'd0,
    ST_DOWN = 2'd1,
    ST_LONG = 2'd2
  } state_e;

  logic [N_CH-1:0] sync1_q, sync2_q;
  logic [N_CH-1:0] s_w;
  logic [N_CH-1:0] level_w, long_w;
  logic [N_CH-1:0] accept_w;

  logic [DW-1:0]   deb_cnt_q [N_CH];
  logic [DW-1:0]   deb_cnt_d [N_CH];
  logic [TW-1:0]   tmr_q     [N_CH];
  logic [TW-1:0]   tmr_d     [N_CH];
  state_e          state_q   [N_CH];
  state_e          state_d   [N_CH];

  logic [N_CH-1:0] press_q, press_d;
  logic [N_CH-1:0] release_q, release_d;
  logic [N_CH-1:0] toggle_q, toggle_d;

  // Inversion sits after the synchroniser so reset leaves every channel released.
  assign s_w = sync2_q ^ INVERT_MASK;

  // Decode the debounced level and long-press flag from channel state.
  always_comb begin
    level_w = '0;
    long_w  = '0;
    for (int i = 0; i < N_CH; i++) begin
      level_w[i] = (state_q[i] != ST_UP);
      long_w[i]  = (state_q[i] == ST_LONG);
    end
  end

  // Debounce: count consecutive cycles where the synced input disagrees with
  // the debounced level; accept the change on the DEBOUNCE_CYC-th one.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    accept_w  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (s_w[i] == level_w[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        deb_cnt_d[i] = '0;
        accept_w[i]  = 1'b1;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
  end

  // Per-channel press/hold/repeat FSM; release always beats a due repeat pulse.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    press_d   = '0;
    release_d = '0;
    toggle_d  = toggle_q;
    for (int i = 0; i < N_CH; i++) begin
      case (state_q[i])
        ST_UP: begin
          if (accept_w[i]) begin
            state_d[i]  = ST_DOWN;
            tmr_d[i]    = HOLD_LOAD;
            press_d[i]  = 1'b1;
            toggle_d[i] = ~toggle_q[i];
          end
        end
        ST_DOWN: begin
          if (accept_w[i]) begin
            state_d[i]   = ST_UP;
            tmr_d[i]     = '0;
            release_d[i] = 1'b1;
          end else if (tmr_q[i] == '0) begin
            state_d[i] = ST_LONG;
            if (REPEAT_MASK[i]) begin
              tmr_d[i]   = REP_LOAD;
              press_d[i] = 1'b1;
            end else begin
              tmr_d[i] = '0;
            end
          end else begin
            tmr_d[i] = tmr_q[i] - 1'b1;
          end
        end
        ST_LONG: begin
          if (accept_w[i]) begin
            state_d[i]   = ST_UP;
            tmr_d[i]     = '0;
            release_d[i] = 1'b1;
          end else if (REPEAT_MASK[i]) begin
            if (tmr_q[i] == '0) begin
              tmr_d[i]   = REP_LOAD;
              press_d[i] = 1'b1;
            end else begin
              tmr_d[i] = tmr_q[i] - 1'b1;
            end
          end
        end
        default: begin
          state_d[i] = ST_UP;
          tmr_d[i]   = '0;
        end
      endcase
      if (toggle_clr[i]) begin
        toggle_d[i] = 1'b0;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      toggle_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        deb_cnt_q[i] <= '0;
        tmr_q[i]     <= '0;
        state_q[i]   <= ST_UP;
      end
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
      for (int i = 0; i < N_CH; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
        tmr_q[i]     <= tmr_d[i];
        state_q[i]   <= state_d[i];
      end
    end
  end

  assign o_level   = level_w;
  assign o_long    = long_w;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_toggle  = toggle_q;

endmodule
